// File: rtl/wb_mprj_decoder_n.sv
// N-slave Wishbone decoder and response mux between the Caravel host port and Neuromorphic_X1_wb macros.
// Optional slave timeout is built when WB_DEC_TIMEOUT_EN is defined.
module wb_mprj_decoder_n #(
    parameter int          N_SLAVES       = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          WIN_BITS       = 12,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_SLAVES-1:0]      m_cyc_o,
    output logic [N_SLAVES-1:0]      m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [N_SLAVES-1:0]      m_ack_i,
    input  logic [32*N_SLAVES-1:0]   m_dat_i,
    input  logic                     err_clr_i,
    output logic                     err_unmapped_o,
    output logic                     err_timeout_o,
    output logic [7:0]               err_cnt_o,
    output logic                     irq_o
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [31:0]   offset, idx_full;
    logic          req, mapped, sel_ack;
    logic          start, slave_done, unmapped_evt, timeout_evt, err_evt, tmo_hit;
    logic [N_SLAVES-1:0] strobe;

    // Unsigned wrap of the subtraction is harmless: the >= check rejects it.
    assign offset   = wbs_adr_i - BASE_ADDR;
    assign idx_full = offset >> WIN_BITS;
    assign mapped   = (wbs_adr_i >= BASE_ADDR) && (idx_full < 32'(N_SLAVES));
    assign req      = wbs_cyc_i & wbs_stb_i;
    assign sel_ack  = m_ack_i[idx_q];
    assign err_evt  = unmapped_evt | timeout_evt;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        slave_done   = 1'b0;
        unmapped_evt = 1'b0;
        timeout_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mapped) begin
                        start   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        unmapped_evt = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            BUSY: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    slave_done = 1'b1;
                    state_d    = RESP;
                end else if (tmo_hit) begin
                    timeout_evt = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from registered state, so async reset drops them at once.
    always_comb begin
        strobe = '0;
        if (state_q == BUSY) strobe[idx_q] = 1'b1;
    end

    assign m_cyc_o = strobe;
    assign m_stb_o = strobe;

`ifdef WB_DEC_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q     <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (start)                 tmo_cnt_q <= '0;
            else if (state_q == BUSY)  tmo_cnt_q <= tmo_cnt_q + 16'd1;
            if (timeout_evt)           err_timeout_o <= 1'b1;
            else if (err_clr_i)        err_timeout_o <= 1'b0;
        end
    end
`else
    assign tmo_hit       = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            m_we_o         <= 1'b0;
            m_sel_o        <= '0;
            m_adr_o        <= '0;
            m_dat_o        <= '0;
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            irq_o          <= 1'b0;
            err_unmapped_o <= 1'b0;
            err_cnt_o      <= '0;
        end else begin
            state_q   <= state_d;
            wbs_ack_o <= slave_done | err_evt;
            irq_o     <= err_evt;
            if (start) begin
                idx_q   <= idx_full[IW-1:0];
                m_we_o  <= wbs_we_i;
                m_sel_o <= wbs_sel_i;
                m_adr_o <= wbs_adr_i;
                m_dat_o <= wbs_dat_i;
            end
            if (slave_done)   wbs_dat_o <= m_dat_i[{idx_q, 5'b0} +: 32];
            else if (err_evt) wbs_dat_o <= ERR_DATA;
            if (unmapped_evt)   err_unmapped_o <= 1'b1;
            else if (err_clr_i) err_unmapped_o <= 1'b0;
            // A new error in the clear cycle restarts the count at one.
            if (err_evt)
                err_cnt_o <= err_clr_i ? 8'd1 : ((err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1);
            else if (err_clr_i)
                err_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_wb_mprj_decoder_n.sv
// Directed bench for wb_mprj_decoder_n: decode, response mux, errors, abort, reset and saturation.
module tb_wb_mprj_decoder_n;

    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           cyc, stb, we, err_clr;
    logic [3:0]     sel;
    logic [31:0]    adr, wdat;
    logic           ack;
    logic [31:0]    rdat;
    logic [NS-1:0]  m_cyc, m_stb, m_ack;
    logic           m_we;
    logic [3:0]     m_sel;
    logic [31:0]    m_adr, m_dat;
    logic [32*NS-1:0] m_dat_in;
    logic           err_unmapped, err_timeout, irq;
    logic [7:0]     err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    wb_mprj_decoder_n #(
        .N_SLAVES(NS), .BASE_ADDR(32'h0000_0000), .WIN_BITS(12),
        .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_adr_o(m_adr), .m_dat_o(m_dat), .m_ack_i(m_ack), .m_dat_i(m_dat_in),
        .err_clr_i(err_clr), .err_unmapped_o(err_unmapped), .err_timeout_o(err_timeout),
        .err_cnt_o(err_cnt), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, " ack"},      32'(ack), 32'd0);
        check({pfx, " rdat"},     rdat, 32'd0);
        check({pfx, " m_cyc"},    32'(m_cyc), 32'd0);
        check({pfx, " m_stb"},    32'(m_stb), 32'd0);
        check({pfx, " m_we"},     32'(m_we), 32'd0);
        check({pfx, " m_sel"},    32'(m_sel), 32'd0);
        check({pfx, " m_adr"},    m_adr, 32'd0);
        check({pfx, " m_dat"},    m_dat, 32'd0);
        check({pfx, " unmapped"}, 32'(err_unmapped), 32'd0);
        check({pfx, " timeout"},  32'(err_timeout), 32'd0);
        check({pfx, " cnt"},      32'(err_cnt), 32'd0);
        check({pfx, " irq"},      32'(irq), 32'd0);
    endtask

    task automatic request(input logic w, input logic [31:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; wdat = d;
    endtask

    task automatic idle_host();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        err_clr = 1'b0; m_ack = '0;
        m_dat_in = {32'hCAFE_0003, 32'hCAFE_0002, 32'h1111_1111, 32'hCAFE_0000};
        tick(); tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // Write to slave 2, slave acks three cycles after its strobe rises
        request(1'b1, 32'h0000_2010, 32'h1234_5678);
        tick();
        check("wr stb onehot", 32'(m_stb), 32'h4);
        check("wr cyc onehot", 32'(m_cyc), 32'h4);
        check("wr m_adr", m_adr, 32'h0000_2010);
        check("wr m_dat", m_dat, 32'h1234_5678);
        check("wr m_we", 32'(m_we), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("wr stb held", 32'(m_stb), 32'h4);
            check("wr no early ack", 32'(ack), 32'd0);
        end
        m_ack = 4'b0100;
        tick();
        check("wr ack", 32'(ack), 32'd1);
        check("wr stb dropped", 32'(m_stb), 32'd0);
        m_ack = '0;
        idle_host();
        tick();
        check("wr ack one cycle", 32'(ack), 32'd0);

        // Read slave 3 with a spurious ack from slave 1
        request(1'b0, 32'h0000_3004, 32'h0);
        tick();
        check("rd stb onehot", 32'(m_stb), 32'h8);
        m_ack = 4'b0010;
        tick();
        check("rd spurious ignored stb", 32'(m_stb), 32'h8);
        check("rd spurious ignored ack", 32'(ack), 32'd0);
        m_ack = 4'b1000;
        tick();
        check("rd ack", 32'(ack), 32'd1);
        check("rd data", rdat, 32'hCAFE_0003);
        check("rd no error", 32'(err_cnt), 32'd0);
        m_ack = '0;
        idle_host();
        tick();

        // Unmapped read, then back-to-back mapped request held through RESP
        request(1'b0, 32'h0000_4000, 32'h0);
        tick();
        exp_cnt = 1;
        check("um no stb", 32'(m_stb), 32'd0);
        check("um ack", 32'(ack), 32'd1);
        check("um data", rdat, 32'hDEAD_BEEF);
        check("um flag", 32'(err_unmapped), 32'd1);
        check("um cnt", 32'(err_cnt), 32'(exp_cnt));
        check("um irq", 32'(irq), 32'd1);
        adr = 32'h0000_0008;
        tick();
        check("b2b idle ack low", 32'(ack), 32'd0);
        check("b2b irq low", 32'(irq), 32'd0);
        tick();
        check("b2b stb slave0", 32'(m_stb), 32'h1);
`ifdef WB_DEC_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) tick();
        check("to stb held 8 cycles", 32'(m_stb), 32'h1);
        tick();
        exp_cnt++;
        check("to ack", 32'(ack), 32'd1);
        check("to data", rdat, 32'hDEAD_BEEF);
        check("to flag", 32'(err_timeout), 32'd1);
        check("to stb dropped", 32'(m_stb), 32'd0);
        check("to irq", 32'(irq), 32'd1);
        check("to cnt", 32'(err_cnt), 32'(exp_cnt));
        idle_host();
        tick();
`else
        for (int c = 0; c < 20; c++) tick();
        check("wait stb held", 32'(m_stb), 32'h1);
        check("wait no timeout", 32'(err_timeout), 32'd0);
        idle_host();
        tick();
        check("abort1 stb low", 32'(m_stb), 32'd0);
        check("abort1 no ack", 32'(ack), 32'd0);
`endif

        // Host abort of a BUSY transaction
        request(1'b0, 32'h0000_0008, 32'h0);
        tick(); tick(); tick();
        idle_host();
        tick();
        check("abort stb low", 32'(m_stb), 32'd0);
        check("abort no ack", 32'(ack), 32'd0);
        check("abort no irq", 32'(irq), 32'd0);
        check("abort cnt", 32'(err_cnt), 32'(exp_cnt));

        // Asynchronous reset in BUSY
        request(1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
        tick();
        check("pre-rst stb", 32'(m_stb), 32'h2);
        #2 rst = 1'b1;
        #1;
        check_reset_state("async rst");
        tick();
        rst = 1'b0;
        idle_host();
        tick();
        request(1'b0, 32'h0000_1000, 32'h0);
        tick();
        check("post-rst stb", 32'(m_stb), 32'h2);
        m_ack = 4'b0010;
        tick();
        check("post-rst ack", 32'(ack), 32'd1);
        check("post-rst data", rdat, 32'h1111_1111);
        m_ack = '0;
        idle_host();
        tick();

        // 300 back-to-back unmapped accesses saturate the counter
        request(1'b0, 32'hFFFF_0000, 32'h0);
        for (int i = 0; i < 600; i++) tick();
        idle_host();
        tick();
        check("sat cnt", 32'(err_cnt), 32'd255);
        check("sat flag", 32'(err_unmapped), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr cnt", 32'(err_cnt), 32'd0);
        check("clr unmapped", 32'(err_unmapped), 32'd0);
        check("clr timeout", 32'(err_timeout), 32'd0);

        // Error in the same cycle as clear wins
        request(1'b0, 32'h0000_5000, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        idle_host();
        check("clr+err cnt", 32'(err_cnt), 32'd1);
        check("clr+err flag", 32'(err_unmapped), 32'd1);
        check("clr+err ack", 32'(ack), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_mprj_decoder_n.md
# wb_mprj_decoder_n

Parametrised N-slave Wishbone decoder/response multiplexer that sits between the Caravel host Wishbone port and N `Neuromorphic_X1_wb` macro instances inside `user_project_wrapper`. It maps each slave to a fixed power-of-two address window and routes one transaction at a time. Selection and response are registered. Unmapped accesses get an error response, and so do slaves that never acknowledge, so the host bus cannot hang.

## Interface
Parameters:
- N_SLAVES, 4, number of slave windows (1..16)
- BASE_ADDR, 32'h0000_0000, start of window 0; must be aligned to the window size
- WIN_BITS, 12, log2 of the window size in bytes (4 KB windows by default)
- TIMEOUT_CYCLES, 255, BUSY cycles without a slave ack before an error response is forced (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on any error response

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host Wishbone controls
- wbs_sel_i  in  4  host byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  host address and write data
- wbs_ack_o  out  1  registered acknowledge to the host
- wbs_dat_o  out  32  registered read data to the host
- m_cyc_o, m_stb_o  out  N_SLAVES each  one-hot per-slave cyc/stb
- m_we_o  out  1  shared; m_sel_o  out  4  shared; m_adr_o, m_dat_o  out  32 each  shared; all latched at request
- m_ack_i  in  N_SLAVES  per-slave acknowledge
- m_dat_i  in  32*N_SLAVES  per-slave read data; slave k occupies bits [32k+31:32k]
- err_clr_i  in  1  synchronous clear of the sticky error status
- err_unmapped_o  out  1  sticky: an unmapped access occurred
- err_timeout_o  out  1  sticky: a slave timed out
- err_cnt_o  out  8  saturating count of error responses
- irq_o  out  1  one-cycle pulse on every error response

## Operation
- Index calculation: idx = (wbs_adr_i - BASE_ADDR) >> WIN_BITS, using unsigned 32-bit subtraction.
- An address is mapped when wbs_adr_i >= BASE_ADDR and idx < N_SLAVES.
- States:
  - IDLE:
    - If wbs_cyc_i & wbs_stb_i and the address is mapped: latch idx, adr, dat, sel and we, then go to BUSY.
    - If the address is unmapped: go to RESP with the error flag set and err_unmapped_o set.
  - BUSY:
    - m_cyc_o[idx] and m_stb_o[idx] are high; every other slave's cyc/stb is low.
    - On m_ack_i[idx]: capture m_dat_i slice idx and go to RESP. Acks from any other slave are ignored.
    - If wbs_cyc_i drops (host abort): go to IDLE. No ack is returned and no error is flagged.
  - RESP:
    - wbs_ack_o = 1 for exactly one cycle; all m_stb_o and m_cyc_o are low.
    - wbs_dat_o = captured data, or ERR_DATA on an error response.
    - Next state is IDLE.
- Error response (unmapped or timeout): err_cnt_o increments, saturating at 255, and irq_o pulses in the RESP cycle.
- err_clr_i clears err_unmapped_o, err_timeout_o and err_cnt_o. If a new error occurs in the same cycle as err_clr_i, the error wins: the flag is set and the count becomes 1.

## Timing
- Reset values:
  - state = IDLE
  - wbs_ack_o = 0, wbs_dat_o = 0
  - m_cyc_o = 0, m_stb_o = 0, m_we_o = 0, m_sel_o = 0, m_adr_o = 0, m_dat_o = 0
  - err flags = 0, err_cnt_o = 0, irq_o = 0
- Reset mid-transaction returns to IDLE immediately (asynchronously) and drops all slave strobes.
- Mapped access: m_stb_o rises 1 cycle after the host request. If the slave acks in cycle L after its strobe rises (L >= 0), wbs_ack_o is high L+1 cycles after that.
- Unmapped access: wbs_ack_o is high in the cycle after the request.
- The decoder holds the host's ack for one cycle only. Back-to-back transactions are accepted: if stb is still high in the IDLE cycle after RESP, it starts a new transaction.
- The slave strobe is held until the slave acks or the transaction is aborted. A slave ack arriving in RESP or IDLE is ignored.

## Configuration
- WB_DEC_TIMEOUT_EN:
  - Defined: a 16-bit counter clears on entering BUSY and counts BUSY cycles. When it reaches TIMEOUT_CYCLES without an ack: drop the slave strobe, go to RESP with ERR_DATA, and set err_timeout_o.
  - Undefined: no counter is built. BUSY waits indefinitely and err_timeout_o is tied to 0.

## Test plan
- N_SLAVES=4, write 32'h1234_5678 to 32'h0000_2010:
  - only m_stb_o[2] rises, 1 cycle after the request
  - m_adr_o=32'h0000_2010, m_dat_o=32'h1234_5678
  - slave acks after 3 cycles, so wbs_ack_o is high 4 cycles after the strobe rose, for exactly 1 cycle
- Read 32'h0000_3004 with slave 3 returning 32'hCAFE_0003 and slave 1 asserting ack spuriously:
  - wbs_dat_o=32'hCAFE_0003
  - the slave-1 ack has no effect
- Read 32'h0000_4000 (unmapped):
  - no m_stb_o asserted
  - ack in the next cycle with 32'hDEAD_BEEF
  - err_unmapped_o=1, err_cnt_o=1, irq_o pulse
- With WB_DEC_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 0 never acks:
  - ack is returned with 32'hDEAD_BEEF after 8 BUSY cycles
  - err_timeout_o=1
  - m_stb_o[0] drops
- Assert wb_rst_i while in BUSY:
  - all outputs return to their reset values without a clock edge
  - the next request after reset release completes normally
- Issue 300 unmapped accesses, then pulse err_clr_i:
  - err_cnt_o saturates at 255
  - err_clr_i clears the flags and the count to 0
